// File: rtl/unified_mem_pkg.sv
// rtl/unified_mem_pkg.sv - shared widths, window bounds, state/region codes and byte-lane merge for unified_mem
package unified_mem_pkg;
  localparam int WORD_W = 32;
  localparam int WE_W = WORD_W / 8;
  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = $clog2(REG_COUNT);
  localparam int MEM_WORDS = 1024;
  localparam int MEM_IDX_W = $clog2(MEM_WORDS);
  localparam logic [WORD_W-1:0] MEM_BASE = 32'h0000_0100;
  localparam logic [WORD_W-1:0] MEM_END = MEM_BASE + WORD_W'(4 * MEM_WORDS);
  localparam logic [WE_W-1:0] WE_FULL = 4'b1111;

  typedef enum logic [1:0] {INIT, CLEAR, READY} state_t;
  typedef enum logic [1:0] {REG, MEM, UNMAPPED} region_t;

  function automatic logic [WORD_W-1:0] merge_bytes(input logic [WORD_W-1:0] old_w,
                                                    input logic [WORD_W-1:0] new_w,
                                                    input logic [WE_W-1:0] we);
    merge_bytes = old_w;
    if (we == WE_FULL) begin
      merge_bytes = new_w;
    end else begin
      for (int k = 0; k < WE_W; k++) begin
        if (we[k]) merge_bytes[8*k +: 8] = new_w[8*k +: 8];
      end
    end
  endfunction
endpackage

// File: rtl/unified_mem_decode.sv
// rtl/unified_mem_decode.sv - combinational address decode into register/memory/unmapped region and word index
module unified_mem_decode
  import unified_mem_pkg::*;
(
  input  logic [WORD_W-1:0]    addr,
  output region_t              region,
  output logic [REG_IDX_W-1:0] reg_idx,
  output logic [MEM_IDX_W-1:0] mem_idx
);

  logic [WORD_W-1:0] off;
  logic unused_bits;

  always_comb begin
    off = addr - MEM_BASE;
    reg_idx = addr[REG_IDX_W-1:0];
    mem_idx = off[MEM_IDX_W+1:2];
    if (addr < WORD_W'(REG_COUNT)) region = REG;
    else if (addr >= MEM_BASE && addr < MEM_END) region = MEM;
    else region = UNMAPPED;
  end

  // byte offset within a word is deliberately ignored
  assign unused_bits = ^{off[WORD_W-1:MEM_IDX_W+2], off[1:0]};

endmodule

// File: rtl/unified_mem.sv
// rtl/unified_mem.sv - two-port register+memory store with post-reset register clear; MEM_BYPASS_EN enables write-first reads
module unified_mem
  import unified_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] A1,
  input  logic [WORD_W-1:0] A2,
  input  logic [WE_W-1:0]   WE1,
  input  logic [WE_W-1:0]   WE2,
  input  logic [WORD_W-1:0] W1,
  input  logic [WORD_W-1:0] W2,
  output logic [WORD_W-1:0] R1,
  output logic [WORD_W-1:0] R2,
  output logic              busy,
  output logic              err1,
  output logic              err2
);

  logic [WORD_W-1:0] regs [REG_COUNT];
  logic [WORD_W-1:0] mem [MEM_WORDS];

  state_t state;
  logic [REG_IDX_W-1:0] idx;

  region_t rg1, rg2;
  logic [REG_IDX_W-1:0] ri1, ri2;
  logic [MEM_IDX_W-1:0] mi1, mi2;

  unified_mem_decode u_dec1 (.addr(A1), .region(rg1), .reg_idx(ri1), .mem_idx(mi1));
  unified_mem_decode u_dec2 (.addr(A2), .region(rg2), .reg_idx(ri2), .mem_idx(mi2));

  logic ready, same, wen1, wen2;
  logic [WORD_W-1:0] cur1, cur2, wd1, wd2, rd1, rd2;

  assign ready = (state == READY);

  always_comb begin
    cur1 = '0;
    cur2 = '0;
    if (rg1 == REG && ri1 != '0) cur1 = regs[ri1];
    else if (rg1 == MEM) cur1 = mem[mi1];
    if (rg2 == REG && ri2 != '0) cur2 = regs[ri2];
    else if (rg2 == MEM) cur2 = mem[mi2];

    same = (rg1 == rg2) && ((rg1 == REG && ri1 == ri2) || (rg1 == MEM && mi1 == mi2));
    wen1 = ready && (WE1 != '0) && (rg1 == MEM || (rg1 == REG && ri1 != '0));
    wen2 = ready && (WE2 != '0) && (rg2 == MEM || (rg2 == REG && ri2 != '0));

    // on a shared target both ports commit one merged word with port 2 lanes on top
    wd2 = merge_bytes(same ? merge_bytes(cur2, W1, WE1) : cur2, W2, WE2);
    wd1 = same ? wd2 : merge_bytes(cur1, W1, WE1);

    rd1 = cur1;
    rd2 = cur2;
`ifdef MEM_BYPASS_EN
    if (wen1) rd1 = wd1;
    if (wen2 && same) rd1 = wd2;
    if (wen2) rd2 = wd2;
    if (wen1 && same) rd2 = wd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (wen1 && rg1 == MEM) mem[mi1] <= wd1;
    if (wen2 && rg2 == MEM) mem[mi2] <= wd2;
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      regs[idx] <= '0;
    end else begin
      if (wen1 && rg1 == REG) regs[ri1] <= wd1;
      if (wen2 && rg2 == REG) regs[ri2] <= wd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      idx   <= '0;
      busy  <= 1'b1;
      R1    <= '0;
      R2    <= '0;
      err1  <= 1'b0;
      err2  <= 1'b0;
    end else begin
      R1   <= ready ? rd1 : '0;
      R2   <= ready ? rd2 : '0;
      err1 <= ready && (rg1 == UNMAPPED);
      err2 <= ready && (rg2 == UNMAPPED);
      case (state)
        INIT: begin
          idx   <= '0;
          state <= CLEAR;
        end
        CLEAR: begin
          idx <= idx + 1'b1;
          if (idx == REG_IDX_W'(REG_COUNT - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: busy <= 1'b0;
        default: begin
          state <= INIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem.sv
// tb/tb_unified_mem.sv - directed bench for unified_mem against a byte-level reference model
module tb_unified_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] A1 = '0, A2 = '0, W1 = '0, W2 = '0;
  logic [3:0] WE1 = '0, WE2 = '0;
  logic [31:0] R1, R2;
  logic busy, err1, err2;

  unified_mem dut (
    .clk(clk), .rst(rst),
    .A1(A1), .A2(A2), .WE1(WE1), .WE2(WE2), .W1(W1), .W2(W2),
    .R1(R1), .R2(R2), .busy(busy), .err1(err1), .err2(err2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  logic [31:0] mmem [1024];
  bit mknown [1024];
  int ph = 0;
  logic [31:0] er1 = '0, er2 = '0;
  bit ee1 = 0, ee2 = 0, eb = 1, ek1 = 1, ek2 = 1;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_reg(input logic [31:0] a);
    return a < 32;
  endfunction

  function automatic bit is_mem(input logic [31:0] a);
    return a >= 32'h100 && a < 32'h100 + 32'd4096;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - 32'h100) / 4);
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (is_reg(a)) return (a == 0) ? 32'h0 : mregs[int'(a)];
    if (is_mem(a)) return mmem[widx(a)];
    return 32'h0;
  endfunction

  function automatic bit known_at(input logic [31:0] a);
    if (is_mem(a)) return mknown[widx(a)];
    return 1'b1;
  endfunction

  task automatic mwrite(input logic [31:0] a, input logic [3:0] we, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      if (we[k]) begin
        if (is_reg(a) && a != 0) mregs[int'(a)][8*k +: 8] = w[8*k +: 8];
        else if (is_mem(a)) mmem[widx(a)][8*k +: 8] = w[8*k +: 8];
      end
    end
    if (is_mem(a) && we == 4'hF) mknown[widx(a)] = 1'b1;
  endtask

  task automatic step(input logic [31:0] a1 = 32'h5, input logic [3:0] we1 = 4'h0,
                      input logic [31:0] w1 = 32'h0, input logic [31:0] a2 = 32'h5,
                      input logic [3:0] we2 = 4'h0, input logic [31:0] w2 = 32'h0);
    logic [31:0] n1, n2;
    bit ne1, ne2, nb, nk1, nk2;
    A1 = a1; WE1 = we1; W1 = w1;
    A2 = a2; WE2 = we2; W2 = w2;
    n1 = '0; n2 = '0; ne1 = 0; ne2 = 0; nk1 = 1; nk2 = 1;
    if (rst) begin
      nb = 1;
      ph = 0;
    end else if (ph < 33) begin
      if (ph > 0) mregs[ph-1] = '0;
      ph++;
      nb = (ph < 33);
    end else begin
      nb = 0;
      n1 = mread(a1); n2 = mread(a2);
      nk1 = known_at(a1); nk2 = known_at(a2);
      ne1 = !is_reg(a1) && !is_mem(a1);
      ne2 = !is_reg(a2) && !is_mem(a2);
      mwrite(a1, we1, w1);
      mwrite(a2, we2, w2);
`ifdef MEM_BYPASS_EN
      n1 = mread(a1); n2 = mread(a2);
      nk1 = known_at(a1); nk2 = known_at(a2);
`endif
    end
    @(posedge clk);
    er1 = n1; er2 = n2; ee1 = ne1; ee2 = ne2; eb = nb; ek1 = nk1; ek2 = nk2;
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      step(32'h5, 4'h0, 32'h0, 32'h3, 4'hF, 32'hFFFF_FFFF);
      n++;
    end
    check(name, n, 33);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(eb));
      check("err1", 32'(err1), 32'(ee1));
      check("err2", 32'(err2), 32'(ee2));
      if (ek1) check("R1", R1, er1);
      if (ek2) check("R2", R2, er2);
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    for (int i = 0; i < 1024; i++) mknown[i] = 1'b0;
    rst = 1'b1;
    step();
    chk_en = 1;
    step();
    check("reset_R1", R1, 32'h0);
    check("reset_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    wait_ready("busy_cycles");
    step(32'h5);
    check("x5_after_clear", R1, 32'h0);
    check("err1_idle", 32'(err1), 32'h0);
    step(32'h3);
    check("busy_write_ignored", R1, 32'h0);

    step(32'h5, 4'h0, 32'h0, 32'h7, 4'hF, 32'hDEAD_BEEF);
    step(32'h7);
    check("x7_read", R1, 32'hDEAD_BEEF);
    step(32'h0, 4'hF, 32'h0000_1234);
    step(32'h0);
    check("x0_read", R1, 32'h0);

    step(32'h104, 4'hF, 32'h1122_3344);
    step(32'h104, 4'b0010, 32'h0000_AA00);
    step(32'h104);
    check("mem104_lane1", R1, 32'h1122_AA44);
    step(32'h106);
    check("mem106_alias", R1, 32'h1122_AA44);

    step(32'h108, 4'hF, 32'h0);
    step(32'h108, 4'b0011, 32'h0000_1111, 32'h108, 4'b0110, 32'h0022_2200);
    step(32'h108);
    check("collision_merge", R1, 32'h0022_2211);

    step(32'h80);
    check("unmapped_R1", R1, 32'h0);
    check("unmapped_err1", 32'(err1), 32'h1);
    step(32'h5);
    check("err1_pulse_end", 32'(err1), 32'h0);
    step(32'h80, 4'hF, 32'hFFFF_FFFF, 32'h1100, 4'hF, 32'h1);
    check("unmapped_err2", 32'(err2), 32'h1);
    step(32'h7, 4'h0, 32'h0, 32'h104);

    step(32'h1F, 4'hF, 32'hA5A5_0031, 32'h20, 4'hF, 32'h1);
    step(32'h1F, 4'h0, 32'h0, 32'hFC);
    check("x31_read", R1, 32'hA5A5_0031);
    check("below_base_err2", 32'(err2), 32'h1);
    step(32'h10FC, 4'hF, 32'h0000_0077);
    step(32'h10FF);
    check("last_mem_word", R1, 32'h0000_0077);

    step(32'h7, 4'hF, 32'hCAFE_0001, 32'h7);
`ifdef MEM_BYPASS_EN
    check("rdw_other_port", R2, 32'hCAFE_0001);
`else
    check("rdw_other_port", R2, 32'hDEAD_BEEF);
`endif
    step(32'h104, 4'h0, 32'h0, 32'h104, 4'b0001, 32'h0000_00EE);
`ifdef MEM_BYPASS_EN
    check("rdw_mem", R1, 32'h1122_AAEE);
`else
    check("rdw_mem", R1, 32'h1122_AA44);
`endif

    step(32'h5, 4'h0, 32'h0, 32'd20, 4'hF, 32'h55);
    step(32'd20);
    check("x20_set", R1, 32'h55);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 11; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready("busy_cycles_restart");
    step(32'd20, 4'h0, 32'h0, 32'h104);
    check("x20_cleared", R1, 32'h0);
    check("mem_kept", R2, mread(32'h104));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
